// File: rtl/player_anim_fsm.sv
// Per-player motion and attack animation controller feeding the sprite renderer.
// Every state, counter and position update waits for frame_tick, so the sprite
// never changes in the middle of a frame.
module player_anim_fsm #(
    parameter int X_INIT   = 100,
    parameter int Y_POS    = 300,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 490,
    parameter int STEP_FWD = 4,
    parameter int STEP_BWD = 2,
    parameter int T_START  = 4,
    parameter int T_END    = 6,
    parameter int T_PULL   = 4,
    parameter bit MIRROR   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       round_reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    output logic [3:0] currentstate,
    output logic [9:0] posx,
    output logic [9:0] posy,
    output logic       attack_active,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        FORWARD      = 4'd1,
        BACKWARD     = 4'd2,
        ATTACK_START = 4'd3,
        ATTACK_END   = 4'd4,
        ATTACK_PULL  = 4'd5
    } state_t;

    localparam int T_MAX_AB = (T_START > T_END) ? T_START : T_END;
    localparam int T_MAX    = (T_MAX_AB > T_PULL) ? T_MAX_AB : T_PULL;
    localparam int CNT_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(T_START - 1);
    localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(T_END - 1);
    localparam logic [CNT_W-1:0] PULL_LAST  = CNT_W'(T_PULL - 1);
    localparam logic [9:0]       X_INIT_V   = 10'(X_INIT);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [9:0]       posx_next;
    logic             atk_pending, pending_next;
    logic             btn_attack_q;
    logic             atk_edge;
    logic             fwd_btn;

    // Saturating increase in 11 bits so the sum can never wrap
    function automatic logic [9:0] sat_inc(input logic [9:0] p, input int step);
        logic [10:0] sum;
        sum = {1'b0, p} + 11'(step);
        if (sum > 11'(X_MAX))
            return 10'(X_MAX);
        return sum[9:0];
    endfunction

    // Saturating decrease: clamp to the left limit instead of underflowing
    function automatic logic [9:0] sat_dec(input logic [9:0] p, input int step);
        if ({1'b0, p} < 11'(X_MIN + step))
            return 10'(X_MIN);
        return p - 10'(step);
    endfunction

    assign atk_edge = btn_attack & ~btn_attack_q;
    assign fwd_btn  = MIRROR ? btn_left : btn_right;

    // Next-state, counter, position and attack-request logic
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        posx_next    = posx;
        pending_next = atk_pending | atk_edge;
        if (frame_tick) begin
            pending_next = 1'b0;
            case (state)
                IDLE, FORWARD, BACKWARD: begin
                    cnt_next = '0;
                    if (atk_pending || atk_edge) begin
                        state_next = ATTACK_START;
                    end else if (btn_left == btn_right) begin
                        state_next = IDLE;
                    end else if (fwd_btn) begin
                        state_next = FORWARD;
                        posx_next  = MIRROR ? sat_dec(posx, STEP_FWD) : sat_inc(posx, STEP_FWD);
                    end else begin
                        state_next = BACKWARD;
                        posx_next  = MIRROR ? sat_inc(posx, STEP_BWD) : sat_dec(posx, STEP_BWD);
                    end
                end
                ATTACK_START: begin
                    if (cnt == START_LAST) begin
                        state_next = ATTACK_END;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                ATTACK_END: begin
                    if (cnt == END_LAST) begin
                        state_next = ATTACK_PULL;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                ATTACK_PULL: begin
                    if (cnt == PULL_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State register with async reset and a synchronous round restart on top
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            posx         <= X_INIT_V;
            atk_pending  <= 1'b0;
            btn_attack_q <= 1'b0;
        end else if (round_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            posx         <= X_INIT_V;
            atk_pending  <= 1'b0;
            btn_attack_q <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            posx         <= posx_next;
            atk_pending  <= pending_next;
            btn_attack_q <= btn_attack;
        end
    end

    assign currentstate  = state;
    assign posy          = 10'(Y_POS);
    assign attack_active = (state == ATTACK_END);
    assign busy          = (state == ATTACK_START) || (state == ATTACK_END) || (state == ATTACK_PULL);

endmodule

// File: tb/tb_player_anim_fsm.sv
// Directed bench for player_anim_fsm: one instance in each mirror orientation
// driven from shared inputs, outputs checked against hand-computed values.
module tb_player_anim_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       round_reset = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_attack = 1'b0;

    logic [3:0] state_n, state_m;
    logic [9:0] posx_n, posx_m, posy_n, posy_m;
    logic       aa_n, aa_m, busy_n, busy_m;

    int compared = 0;
    int mismatched = 0;

    player_anim_fsm #(.MIRROR(1'b0)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .round_reset(round_reset),
        .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
        .currentstate(state_n), .posx(posx_n), .posy(posy_n),
        .attack_active(aa_n), .busy(busy_n)
    );

    player_anim_fsm #(.MIRROR(1'b1)) dut_m (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .round_reset(round_reset),
        .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
        .currentstate(state_m), .posx(posx_m), .posy(posy_m),
        .attack_active(aa_m), .busy(busy_m)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Sets the buttons, then issues n frame ticks; returns on a falling edge
    task automatic applyStimulus(input logic l, input logic r, input int n);
        btn_left  = l;
        btn_right = r;
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulseAttack();
        btn_attack = 1'b1;
        @(negedge clk);
        btn_attack = 1'b0;
        @(negedge clk);
    endtask

    task automatic roundRestart();
        round_reset = 1'b1;
        @(negedge clk);
        round_reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Async reset in the middle of a frame
        applyStimulus(1'b0, 1'b1, 2);
        checkOutput("pre_reset_posx", posx_n, 108);
        btn_right = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_state", state_n, 0);
        checkOutput("rst_posx", posx_n, 100);
        checkOutput("rst_posy", posy_n, 300);
        checkOutput("rst_attack", aa_n, 0);
        checkOutput("rst_busy", busy_n, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Forward motion and release
        applyStimulus(1'b0, 1'b1, 5);
        checkOutput("fwd_state", state_n, 1);
        checkOutput("fwd_posx", posx_n, 120);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("rel_state", state_n, 0);
        checkOutput("rel_posx", posx_n, 120);
        btn_right = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("no_tick_hold", posx_n, 120);

        // Right saturation
        roundRestart();
        checkOutput("rr_posx", posx_n, 100);
        applyStimulus(1'b0, 1'b1, 97);
        checkOutput("sat_r_97", posx_n, 488);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("sat_r_98", posx_n, 490);
        applyStimulus(1'b0, 1'b1, 3);
        checkOutput("sat_r_hold", posx_n, 490);
        checkOutput("sat_r_state", state_n, 1);

        // Left saturation
        roundRestart();
        applyStimulus(1'b1, 1'b0, 50);
        checkOutput("sat_l_50", posx_n, 0);
        checkOutput("sat_l_state", state_n, 2);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("sat_l_51", posx_n, 0);
        checkOutput("sat_l_state51", state_n, 2);

        // Full attack sequence with a dropped second press
        roundRestart();
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("atk_pre_posx", posx_n, 104);
        pulseAttack();
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("atk_enter", state_n, 3);
        checkOutput("atk_enter_posx", posx_n, 104);
        checkOutput("atk_enter_busy", busy_n, 1);
        checkOutput("atk_enter_aa", aa_n, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1);
            checkOutput("atk_start_hold", state_n, 3);
        end
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("atk_end", state_n, 4);
        checkOutput("atk_end_aa", aa_n, 1);
        pulseAttack();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1);
            checkOutput("atk_end_hold", state_n, 4);
        end
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("atk_pull", state_n, 5);
        checkOutput("atk_pull_aa", aa_n, 0);
        checkOutput("atk_pull_busy", busy_n, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1);
            checkOutput("atk_pull_hold", state_n, 5);
        end
        checkOutput("atk_frozen_posx", posx_n, 104);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("atk_exit", state_n, 0);
        checkOutput("atk_exit_busy", busy_n, 0);
        checkOutput("atk_exit_posx", posx_n, 104);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("atk_resume", state_n, 1);
        checkOutput("atk_resume_posx", posx_n, 108);

        // Attack edge arriving in the same clock as the tick
        btn_attack = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        btn_attack = 1'b0;
        @(negedge clk);
        checkOutput("same_clk_edge", state_n, 3);

        // Mirrored instance
        roundRestart();
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("mir_state", state_m, 1);
        checkOutput("mir_posx", posx_m, 96);
        checkOutput("nomir_state", state_n, 2);
        checkOutput("nomir_posx", posx_n, 98);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("mir_both_state", state_m, 0);
        checkOutput("mir_both_posx", posx_m, 96);

        // round_reset in the middle of ATTACK_END
        roundRestart();
        applyStimulus(1'b0, 1'b1, 1);
        pulseAttack();
        applyStimulus(1'b0, 1'b0, 5);
        checkOutput("rr_atk_state", state_n, 4);
        checkOutput("rr_atk_aa", aa_n, 1);
        round_reset = 1'b1;
        @(negedge clk);
        round_reset = 1'b0;
        checkOutput("rr_state", state_n, 0);
        checkOutput("rr_posx2", posx_n, 100);
        checkOutput("rr_aa", aa_n, 0);
        checkOutput("rr_busy", busy_n, 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("rr_after_tick", state_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/player_anim_fsm.md
Name: player_anim_fsm

Overview:
- Per-player motion and animation controller that sits directly upstream of the sprite ROM renderer.
- Converts button inputs into the 4-bit animation state code plus the sprite top-left position (posx, posy) that the renderer consumes.
- All motion and animation timing advances only on a once-per-frame tick, so the sprite never changes mid-frame.
- One instance is used per player; MIRROR flips which button means "forward".

Parameters:
- X_INIT, 100: posx after reset or round_reset.
- Y_POS, 300: constant posy.
- X_MIN, 0: left position limit.
- X_MAX, 490: right position limit, equal to 640 minus the 150-pixel sprite width.
- STEP_FWD, 4: pixels moved per tick in FORWARD.
- STEP_BWD, 2: pixels moved per tick in BACKWARD.
- T_START, 4: ticks spent in ATTACK_START.
- T_END, 6: ticks spent in ATTACK_END.
- T_PULL, 4: ticks spent in ATTACK_PULL.
- MIRROR, 0: 0 means forward is right; 1 means forward is left.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  asynchronous active-high reset.
- frame_tick  in  1  one-clk pulse per frame (at vsync start).
- round_reset  in  1  synchronous return to start condition.
- btn_left  in  1  synchronized level.
- btn_right  in  1  synchronized level.
- btn_attack  in  1  synchronized level.
- currentstate  out  4  animation code: 0 IDLE, 1 FORWARD, 2 BACKWARD, 3 ATTACK_START, 4 ATTACK_END, 5 ATTACK_PULL.
- posx  out  10  sprite left x.
- posy  out  10  sprite top y; always Y_POS.
- attack_active  out  1  hitbox valid; high iff currentstate==4.
- busy  out  1  high in states 3, 4 and 5.

Behaviour:
- Reset: clk is the clock; rst is asynchronous, active-high. Reset values:
  - currentstate=0, posx=X_INIT, posy=Y_POS.
  - attack_active=0, busy=0.
  - internal counter cnt=0, atk_pending=0, btn_attack_q=0.
- round_reset: same effect as rst, applied synchronously. It has priority over frame_tick and over all other logic.
- Attack capture (every clk):
  - btn_attack_q <= btn_attack.
  - A rising edge (btn_attack & ~btn_attack_q) sets atk_pending.
  - atk_pending is cleared on every frame_tick, whether the request is consumed or ignored. Presses made during an attack are therefore dropped, not buffered.
  - If an edge and a frame_tick occur in the same clk, the edge is taken into account by that tick's decision.
- State updates happen only on clk cycles with frame_tick=1. Outputs hold between ticks.
- Free states (IDLE, FORWARD, BACKWARD), next state by priority:
  1. atk_pending or an edge this cycle -> ATTACK_START; cnt=0; posx unchanged.
  2. btn_left==btn_right (both or neither) -> IDLE.
  3. Forward button alone -> FORWARD. The forward button is btn_right when MIRROR=0 and btn_left when MIRROR=1.
  4. Other button alone -> BACKWARD.
- Movement applies in the same tick as the state decision, using the next state:
  - FORWARD: posx moves STEP_FWD toward the forward direction.
  - BACKWARD: posx moves STEP_BWD away from it.
- Arithmetic is done in 11 bits with saturation:
  - Increase: if posx+step > X_MAX then X_MAX.
  - Decrease: if posx < X_MIN+step then X_MIN.
  - posx never leaves [X_MIN, X_MAX] and never wraps.
- Attack states: at each tick,
  - if cnt==T_state-1: advance and set cnt=0. The sequence is START -> END -> PULL -> IDLE.
  - otherwise cnt++.
- Each attack state lasts exactly T ticks, so a full attack takes T_START+T_END+T_PULL ticks.
- During an attack, buttons are ignored and posx is frozen.
- Leaving ATTACK_PULL always goes to IDLE; movement resumes from the following tick.
- attack_active and busy are decoded from the registered state, so they align with currentstate in the same cycle.
- cnt is sized for max(T)-1 and is held at 0 outside attack states.

Test Plan:
- Reset check: assert rst mid-frame -> immediately currentstate=0, posx=100, posy=300, attack_active=0, busy=0.
- Forward motion: MIRROR=0, hold btn_right for 5 ticks -> state 1, posx=120. Release, 1 tick -> state 0, posx=120.
- Right saturation: hold btn_right from posx=100.
  - After 97 ticks, posx=488.
  - Tick 98 -> posx=490; further ticks stay at 490.
- Left saturation: hold btn_left from posx=100, BACKWARD.
  - After 50 ticks, posx=0.
  - Tick 51 -> posx=0, state 2.
- Attack sequence: hold btn_right and pulse btn_attack for 1 clk between ticks.
  - Next tick -> state 3, posx unchanged.
  - Then 4 ticks in state 3, 6 ticks in state 4 (attack_active=1), 4 ticks in state 5, then state 0.
  - Next tick -> state 1.
  - A second attack press during state 4 is ignored.
- Mirror and round_reset: with MIRROR=1, btn_left for 1 tick -> state 1, posx=96. Both buttons held -> state 0, posx held.
  - round_reset during state 4 -> next clk state 0, posx=100, attack_active=0.
